cache_evict_fill: RTL and testbench

Line replacement sequencer for the L1 caches. On a miss it takes the one-hot victim way chosen by the replacement policy and writes the victim line back over the bus beat by beat if it is dirty. It then fetches the missing line beat by beat and commits it to the victim way. The commit is a single cycle that asserts way write enable, SetValid and LRUWriteEn. The block sits between the cache controller FSM, the way/tag arrays and the bus interface.

---
 rtl/cache_evict_fill.sv | 144 ++++++++++++++
 tb/tb_cache_evict_fill.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_evict_fill.sv
// cache_evict_fill: line replacement sequencer for the L1 caches.
// On a miss, writes back a dirty victim line beat by beat, fetches the
// missing line beat by beat, then commits it to the victim way in one cycle.
// Optional feature macro: CACHE_EVICT_WBBUF_EN -- the dirty victim is held in
// an internal writeback buffer and drained after the commit, so the fill
// reaches the cache without waiting for the eviction.
module cache_evict_fill #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 7,
  parameter int TAGLEN    = 20,
  parameter int LINELEN   = 512,
  parameter int AHBW      = 64,
  localparam int BEATS     = LINELEN / AHBW,
  localparam int OFFSETLEN = $clog2(LINELEN / 8),
  localparam int PALEN     = TAGLEN + SETLEN + OFFSETLEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  output logic               Ready,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimValid,
  input  logic               VictimDirty,
  input  logic [TAGLEN-1:0]  VictimTag,
  input  logic [LINELEN-1:0] VictimLine,
  input  logic [TAGLEN-1:0]  MissTag,
  input  logic [SETLEN-1:0]  SetIdx,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PALEN-1:0]   BusAdr,
  output logic [AHBW-1:0]    BusWData,
  input  logic               BusAck,
  input  logic [AHBW-1:0]    BusRData,
  output logic [LINELEN-1:0] FillLine,
  output logic [NUMWAYS-1:0] FillWayEn,
  output logic               SetValid,
  output logic               ClearDirty,
  output logic               LRUWriteEn,
  output logic               Done
);

  localparam int BEAT_W = $clog2(BEATS);
  // byte offset bits below the beat index are always zero
  localparam int ADR_SH = OFFSETLEN - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

`ifdef CACHE_EVICT_WBBUF_EN
  localparam bit WBBUF = 1'b1;
`else
  localparam bit WBBUF = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [NUMWAYS-1:0]  way_q;
  logic                dirty_q;
  logic [TAGLEN-1:0]   vtag_q, mtag_q;
  logic [SETLEN-1:0]   set_q;
  logic [LINELEN-1:0]  line_q;
  logic                commit;
  logic                beat_done;

  assign beat_done  = BusAck && (beat_q == LAST_BEAT);
  assign SetValid   = commit;
  assign ClearDirty = commit;
  assign LRUWriteEn = commit;
  assign Done       = commit;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and Moore-style bus / commit outputs
  always_comb begin
    state_d   = state_q;
    Ready     = 1'b0;
    BusReq    = 1'b0;
    BusWrite  = 1'b0;
    BusAdr    = '0;
    BusWData  = '0;
    FillWayEn = '0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        Ready = 1'b1;
        if (Start)
          state_d = (!WBBUF && VictimValid && VictimDirty) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        BusReq   = 1'b1;
        BusWrite = 1'b1;
        BusAdr   = PALEN'({vtag_q, set_q, beat_q}) << ADR_SH;
        BusWData = line_q[beat_q * AHBW +: AHBW];
        // with the buffer the drain is the last step, otherwise the fetch follows
        if (beat_done) state_d = WBBUF ? IDLE : FETCH;
      end
      FETCH: begin
        BusReq = 1'b1;
        BusAdr = PALEN'({mtag_q, set_q, beat_q}) << ADR_SH;
        if (beat_done) state_d = COMMIT;
      end
      COMMIT: begin
        FillWayEn = way_q;
        commit    = 1'b1;
        state_d   = (WBBUF && dirty_q) ? WRITEBACK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch, beat counter and fill line assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q   <= '0;
      way_q    <= '0;
      dirty_q  <= 1'b0;
      vtag_q   <= '0;
      mtag_q   <= '0;
      set_q    <= '0;
      line_q   <= '0;
      FillLine <= '0;
    end else begin
      if (state_q == IDLE && Start) begin
        beat_q  <= '0;
        way_q   <= VictimWay;
        dirty_q <= VictimValid & VictimDirty;
        vtag_q  <= VictimTag;
        mtag_q  <= MissTag;
        set_q   <= SetIdx;
        line_q  <= VictimLine;
      end else if ((state_q == WRITEBACK || state_q == FETCH) && BusAck) begin
        // natural wrap leaves the counter at 0 for the next phase
        beat_q <= beat_q + 1'b1;
      end
      if (state_q == FETCH && BusAck)
        FillLine[beat_q * AHBW +: AHBW] <= BusRData;
    end
  end

endmodule

// File: tb/tb_cache_evict_fill.sv
// Randomized bench for cache_evict_fill: each miss is turned into an ordered
// list of expected bus beats and the commit, derived from the miss inputs,
// and the DUT is walked through that list with random bus wait states.
module tb_cache_evict_fill;
  localparam int NUMWAYS   = 4;
  localparam int SETLEN    = 7;
  localparam int TAGLEN    = 20;
  localparam int LINELEN   = 512;
  localparam int AHBW      = 64;
  localparam int BEATS     = LINELEN / AHBW;
  localparam int OFFSETLEN = $clog2(LINELEN / 8);
  localparam int PALEN     = TAGLEN + SETLEN + OFFSETLEN;
`ifdef CACHE_EVICT_WBBUF_EN
  localparam bit WBBUF = 1'b1;
`else
  localparam bit WBBUF = 1'b0;
`endif

  logic               clk, reset, Start, Ready;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimValid, VictimDirty;
  logic [TAGLEN-1:0]  VictimTag, MissTag;
  logic [LINELEN-1:0] VictimLine;
  logic [SETLEN-1:0]  SetIdx;
  logic               BusReq, BusWrite, BusAck;
  logic [PALEN-1:0]   BusAdr;
  logic [AHBW-1:0]    BusWData, BusRData;
  logic [LINELEN-1:0] FillLine;
  logic [NUMWAYS-1:0] FillWayEn;
  logic               SetValid, ClearDirty, LRUWriteEn, Done;

  cache_evict_fill #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN), .LINELEN(LINELEN), .AHBW(AHBW)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .Ready(Ready),
    .VictimWay(VictimWay), .VictimValid(VictimValid), .VictimDirty(VictimDirty),
    .VictimTag(VictimTag), .VictimLine(VictimLine), .MissTag(MissTag), .SetIdx(SetIdx),
    .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData), .FillLine(FillLine), .FillWayEn(FillWayEn),
    .SetValid(SetValid), .ClearDirty(ClearDirty), .LRUWriteEn(LRUWriteEn), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = write beat, 1 = read beat, 2 = commit
  typedef struct {
    int              kind;
    logic [PALEN-1:0] adr;
    logic [AHBW-1:0]  data;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [LINELEN-1:0] got, input logic [LINELEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINELEN-1:0] rand_line();
    logic [LINELEN-1:0] l;
    for (int i = 0; i < LINELEN / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [AHBW-1:0] rand_beat();
    logic [AHBW-1:0] b;
    for (int i = 0; i < AHBW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // byte address of beat b of the line {tag,set}
  function automatic logic [PALEN-1:0] beat_adr(input logic [TAGLEN-1:0] tag,
                                                 input logic [SETLEN-1:0] set, input int b);
    return (PALEN'(tag) << (SETLEN + OFFSETLEN)) | (PALEN'(set) << OFFSETLEN) |
           PALEN'(b * (AHBW / 8));
  endfunction

  task automatic push_writes(input logic [TAGLEN-1:0] tag, input logic [SETLEN-1:0] set,
                             input logic [LINELEN-1:0] line);
    ev_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.kind = 0; e.adr = beat_adr(tag, set, b); e.data = line[b*AHBW +: AHBW];
      q.push_back(e);
    end
  endtask

  // scramble request inputs while busy: none of it may be sampled
  task automatic scramble();
    Start       = 1'($urandom_range(0, 1));
    VictimWay   = NUMWAYS'($urandom());
    VictimValid = 1'($urandom_range(0, 1));
    VictimDirty = 1'($urandom_range(0, 1));
    VictimTag   = TAGLEN'($urandom());
    MissTag     = TAGLEN'($urandom());
    SetIdx      = SETLEN'($urandom());
    VictimLine  = rand_line();
  endtask

  task automatic run_miss(input logic [NUMWAYS-1:0] way, input logic v, input logic d,
                          input logic [TAGLEN-1:0] vtag, input logic [TAGLEN-1:0] mtag,
                          input logic [SETLEN-1:0] set, input logic [LINELEN-1:0] line,
                          input int ack_pct, input int stall_beat, input int stall_len,
                          input int abort_after);
    logic [LINELEN-1:0] exp_fill = '0;
    logic [AHBW-1:0]    rd;
    ev_t e;
    int  rd_n = 0, waits = 0, cyc = 0, stall_cnt = 0, exp_done;
    bit  committed = 0, ack;
    q.delete();
    if (v && d && !WBBUF) push_writes(vtag, set, line);
    for (int b = 0; b < BEATS; b++) begin
      e.kind = 1; e.adr = beat_adr(mtag, set, b); e.data = '0;
      q.push_back(e);
    end
    e.kind = 2; e.adr = '0; e.data = '0;
    q.push_back(e);
    if (v && d && WBBUF) push_writes(vtag, set, line);
    exp_done = ((v && d && !WBBUF) ? 2 * BEATS : BEATS) + 1;

    @(negedge clk);
    chk("ready_idle", Ready, 1'b1);
    chk("busreq_idle", BusReq, 1'b0);
    Start = 1'b1; VictimWay = way; VictimValid = v; VictimDirty = d;
    VictimTag = vtag; MissTag = mtag; SetIdx = set; VictimLine = line;
    BusAck = 1'($urandom_range(0, 1)); BusRData = rand_beat();

    while (q.size() > 0) begin
      @(negedge clk);
      cyc++;
      scramble();
      if (cyc > 400) begin
        chk("timeout", 1'b1, 1'b0);
        q.delete();
        break;
      end
      chk("ready_busy", Ready, 1'b0);
      if (q[0].kind == 2) begin
        chk("done_cycle", cyc, exp_done + waits);
        chk("done", Done, 1'b1);
        chk("set_valid", SetValid, 1'b1);
        chk("clear_dirty", ClearDirty, 1'b1);
        chk("lru_we", LRUWriteEn, 1'b1);
        chk("fill_way_en", FillWayEn, way);
        chk("busreq_commit", BusReq, 1'b0);
        chk("fill_line", FillLine, exp_fill);
        BusAck = 1'($urandom_range(0, 1));
        BusRData = rand_beat();
        committed = 1;
        void'(q.pop_front());
      end else begin
        chk("done_beat", Done, 1'b0);
        chk("way_en_beat", FillWayEn, '0);
        chk("busreq", BusReq, 1'b1);
        chk("buswrite", BusWrite, q[0].kind == 0);
        chk("busadr", BusAdr, q[0].adr);
        if (q[0].kind == 0) chk("buswdata", BusWData, q[0].data);
        if (q[0].kind == 1 && rd_n == abort_after) begin
          reset = 1'b1; BusAck = 1'b0; Start = 1'b0;
          #1;
          chk("abort_ready", Ready, 1'b1);
          chk("abort_fill", FillLine, '0);
          chk("abort_busreq", BusReq, 1'b0);
          chk("abort_way_en", FillWayEn, '0);
          chk("abort_done", Done, 1'b0);
          @(negedge clk);
          chk("abort_hold_ready", Ready, 1'b1);
          chk("abort_hold_done", Done, 1'b0);
          reset = 1'b0;
          q.delete();
          return;
        end
        ack = ($urandom_range(1, 100) <= ack_pct);
        if (q[0].kind == 1 && rd_n == stall_beat && stall_cnt < stall_len) begin
          ack = 1'b0;
          stall_cnt++;
        end
        rd = rand_beat();
        BusAck = ack; BusRData = rd;
        if (ack) begin
          if (q[0].kind == 1) begin
            exp_fill[rd_n*AHBW +: AHBW] = rd;
            rd_n++;
          end
          void'(q.pop_front());
        end else if (!committed) begin
          waits++;
        end
      end
    end
  endtask

  initial begin
    logic [NUMWAYS-1:0] way;
    reset = 1'b1; Start = 1'b0; BusAck = 1'b1; BusRData = '0;
    VictimWay = '0; VictimValid = 1'b0; VictimDirty = 1'b0;
    VictimTag = '0; MissTag = '0; SetIdx = '0; VictimLine = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", Ready, 1'b1);
    chk("rst_busreq", BusReq, 1'b0);
    chk("rst_buswrite", BusWrite, 1'b0);
    chk("rst_busadr", BusAdr, '0);
    chk("rst_buswdata", BusWData, '0);
    chk("rst_fill", FillLine, '0);
    chk("rst_way_en", FillWayEn, '0);
    chk("rst_pulses", {Done, SetValid, ClearDirty, LRUWriteEn}, 4'b0);
    reset = 1'b0;
    BusAck = 1'b0;

    // clean victim, no wait states
    run_miss(4'b0100, 1'b1, 1'b0, 20'h00111, 20'h12345, 7'h05, rand_line(), 100, -1, 0, -1);
    // dirty victim, back-to-back with the previous miss
    run_miss(4'b0010, 1'b1, 1'b1, 20'h00ABC, 20'h12345, 7'h05, rand_line(), 100, -1, 0, -1);
    // three wait states on fetch beat 2
    run_miss(4'b1000, 1'b1, 1'b0, 20'h00ABC, 20'h54321, 7'h11, rand_line(), 100, 2, 3, -1);
    // invalid but dirty victim behaves as a clean miss
    run_miss(4'b0001, 1'b0, 1'b1, 20'hFFFFF, 20'h0BEEF, 7'h7F, rand_line(), 100, -1, 0, -1);
    // reset during fetch beat 5
    run_miss(4'b0100, 1'b1, 1'b0, 20'h00001, 20'h22222, 7'h33, rand_line(), 100, -1, 0, 5);
    // dirty victim with wait states on the write side too
    run_miss(4'b0001, 1'b1, 1'b1, 20'h3C3C3, 20'h0F0F0, 7'h00, rand_line(), 60, 0, 2, -1);

    for (int n = 0; n < 40; n++) begin
      way = NUMWAYS'(1) << $urandom_range(0, NUMWAYS - 1);
      run_miss(way, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               TAGLEN'($urandom()), TAGLEN'($urandom()), SETLEN'($urandom()), rand_line(),
               $urandom_range(40, 100), -1, 0, -1);
    end

    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    chk("final_ready", Ready, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
